// File: rtl/i8253_pkg.sv
// Shared types and control-word helpers for the i8253 request sequencer.
package i8253_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_CW   = 3'd1,
      ST_GAP1 = 3'd2,
      ST_LO   = 3'd3,
      ST_GAP2 = 3'd4,
      ST_HI   = 3'd5,
      ST_GAP3 = 3'd6,
      ST_FIN  = 3'd7
   } seq_state_t;

   typedef enum logic {
      OP_PROG = 1'b0,
      OP_READ = 1'b1
   } op_t;

   // Address of the timer control-word register; also the rejected channel code.
   localparam logic [1:0] A_CTRL       = 2'd3;
   localparam logic [1:0] CHAN_ILLEGAL = 2'd3;

   // Control word for programming: select channel, access LSB then MSB, mode, BCD.
   function automatic logic [7:0] cw_prog(input logic [1:0] chan,
                                          input logic [2:0] mode,
                                          input logic       bcd);
      return {chan, 2'b11, mode, bcd};
   endfunction

   // Counter-latch command for the given channel.
   function automatic logic [7:0] cw_latch(input logic [1:0] chan);
      return {chan, 2'b00, 4'b0000};
   endfunction

endpackage

// File: rtl/i8253_rr_arb.sv
// Round-robin arbiter: searches from the rotating pointer, moves it past each grant.
module i8253_rr_arb #(
   parameter int NREQ = 3,
   localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [NREQ-1:0]  req,
   input  logic             advance,
   output logic [NREQ-1:0]  grant,
   output logic [IDX_W-1:0] grant_idx
);

   logic [IDX_W-1:0] ptr_r;
   logic [IDX_W-1:0] cand_s;
   logic [IDX_W-1:0] idx_s;
   logic             found_s;

   // First requester at or after the pointer, wrapping around.
   always_comb begin
      cand_s  = '0;
      idx_s   = '0;
      found_s = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         cand_s = IDX_W'((int'(ptr_r) + i) % NREQ);
         if (!found_s && req[cand_s]) begin
            found_s = 1'b1;
            idx_s   = cand_s;
         end else begin
            found_s = found_s || 1'b0;
         end
      end
   end

   assign grant     = found_s ? (NREQ'(1'b1) << idx_s) : '0;
   assign grant_idx = idx_s;

   // Pointer moves to the index after the one just granted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_r <= '0;
      end else if (advance) begin
         ptr_r <= ((int'(idx_s) + 1) >= NREQ) ? '0 : idx_s + IDX_W'(1);
      end
   end

endmodule

// File: rtl/i8253_sequencer.sv
// Multi-requester front end: turns program/read requests into i8253 bus cycles.
module i8253_sequencer #(
   parameter int NREQ       = 3,
   parameter int STROBE_GAP = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [NREQ-1:0]   req_op,
   input  logic [NREQ*2-1:0] req_chan,
   input  logic [NREQ*3-1:0] req_mode,
   input  logic [NREQ-1:0]   req_bcd,
   input  logic [NREQ*16-1:0] req_count,
   output logic [NREQ-1:0]   done,
   output logic              err,
   output logic [15:0]       rdata,
   output logic [1:0]        t_a,
   output logic              t_wr,
   output logic              t_rd,
   output logic [7:0]        t_din,
   input  logic [7:0]        t_dout
);
   import i8253_pkg::*;

   localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [2:0] GAP_LOAD = (STROBE_GAP > 0) ? 3'(STROBE_GAP - 1) : 3'd0;

   seq_state_t        state_r, state_nxt_s;
   logic [2:0]        gap_r, gap_nxt_s;
   logic [NREQ-1:0]   grant_oh_s;
   logic [IDX_W-1:0]  grant_idx_s;
   logic              advance_s;

   logic [1:0]        chan_a_s  [NREQ];
   logic [2:0]        mode_a_s  [NREQ];
   logic [15:0]       count_a_s [NREQ];
   op_t               sel_op_s;
   logic [1:0]        sel_chan_s;
   logic [2:0]        sel_mode_s;
   logic              sel_bcd_s;
   logic [15:0]       sel_count_s;

   op_t               op_r;
   logic [1:0]        chan_r;
   logic [15:0]       count_r;
   logic [NREQ-1:0]   owner_r;
   logic [7:0]        lo_byte_r, hi_byte_r, hi_byte_s;

   logic [NREQ-1:0]   done_r, done_nxt_s;
   logic              err_r, err_nxt_s;
   logic [15:0]       rdata_r, rdata_nxt_s;
   logic [1:0]        t_a_r, t_a_nxt_s;
   logic              t_wr_r, t_wr_nxt_s, t_rd_r, t_rd_nxt_s;
   logic [7:0]        t_din_r, t_din_nxt_s;

   i8253_rr_arb #(.NREQ(NREQ)) u_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req_valid),
      .advance   (advance_s),
      .grant     (grant_oh_s),
      .grant_idx (grant_idx_s)
   );

   // Unpack the flat request payload buses into per-requester arrays.
   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         chan_a_s[i]  = req_chan[2*i +: 2];
         mode_a_s[i]  = req_mode[3*i +: 3];
         count_a_s[i] = req_count[16*i +: 16];
      end
   end

   assign sel_op_s    = op_t'(req_op[grant_idx_s]);
   assign sel_chan_s  = chan_a_s[grant_idx_s];
   assign sel_mode_s  = mode_a_s[grant_idx_s];
   assign sel_bcd_s   = req_bcd[grant_idx_s];
   assign sel_count_s = count_a_s[grant_idx_s];

   // The MSB read byte is taken straight from the pins when FIN follows HI directly.
   assign hi_byte_s = (state_r == ST_HI) ? t_dout : hi_byte_r;

   // Next-state logic: grant in IDLE, then strobe / gap phases, then FIN.
   always_comb begin
      state_nxt_s = state_r;
      gap_nxt_s   = gap_r;
      advance_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (|req_valid) begin
               advance_s   = 1'b1;
               state_nxt_s = (sel_chan_s == CHAN_ILLEGAL) ? ST_FIN : ST_CW;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_CW, ST_LO, ST_HI: begin
            if (STROBE_GAP == 0) begin
               state_nxt_s = (state_r == ST_CW) ? ST_LO : (state_r == ST_LO) ? ST_HI : ST_FIN;
            end else begin
               state_nxt_s = (state_r == ST_CW) ? ST_GAP1 : (state_r == ST_LO) ? ST_GAP2 : ST_GAP3;
               gap_nxt_s   = GAP_LOAD;
            end
         end
         ST_GAP1, ST_GAP2, ST_GAP3: begin
            if (gap_r == 3'd0) begin
               state_nxt_s = (state_r == ST_GAP1) ? ST_LO : (state_r == ST_GAP2) ? ST_HI : ST_FIN;
            end else begin
               gap_nxt_s = gap_r - 3'd1;
            end
         end
         ST_FIN:  state_nxt_s = ST_IDLE;
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Output values for the state being entered; they are registered with the state.
   always_comb begin
      t_a_nxt_s   = t_a_r;
      t_din_nxt_s = t_din_r;
      t_wr_nxt_s  = 1'b0;
      t_rd_nxt_s  = 1'b0;
      done_nxt_s  = '0;
      err_nxt_s   = 1'b0;
      rdata_nxt_s = rdata_r;
      case (state_nxt_s)
         ST_CW: begin
            t_a_nxt_s   = A_CTRL;
            t_wr_nxt_s  = 1'b1;
            t_din_nxt_s = (sel_op_s == OP_READ) ? cw_latch(sel_chan_s)
                                                : cw_prog(sel_chan_s, sel_mode_s, sel_bcd_s);
         end
         ST_LO, ST_HI: begin
            t_a_nxt_s = chan_r;
            if (op_r == OP_READ) begin
               t_rd_nxt_s = 1'b1;
            end else begin
               t_wr_nxt_s  = 1'b1;
               t_din_nxt_s = (state_nxt_s == ST_LO) ? count_r[7:0] : count_r[15:8];
            end
         end
         ST_FIN: begin
            if (state_r == ST_IDLE) begin
               done_nxt_s = grant_oh_s;
               err_nxt_s  = 1'b1;
            end else begin
               done_nxt_s  = owner_r;
               rdata_nxt_s = (op_r == OP_READ) ? {hi_byte_s, lo_byte_r} : rdata_r;
            end
         end
         default: begin
            t_wr_nxt_s = 1'b0;
         end
      endcase
   end

   // State, gap counter and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         gap_r   <= 3'd0;
         done_r  <= '0;
         err_r   <= 1'b0;
         rdata_r <= 16'd0;
         t_a_r   <= 2'd0;
         t_wr_r  <= 1'b0;
         t_rd_r  <= 1'b0;
         t_din_r <= 8'd0;
      end else begin
         state_r <= state_nxt_s;
         gap_r   <= gap_nxt_s;
         done_r  <= done_nxt_s;
         err_r   <= err_nxt_s;
         rdata_r <= rdata_nxt_s;
         t_a_r   <= t_a_nxt_s;
         t_wr_r  <= t_wr_nxt_s;
         t_rd_r  <= t_rd_nxt_s;
         t_din_r <= t_din_nxt_s;
      end
   end

   // Payload capture at grant, and read-byte capture during each read strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_r      <= OP_PROG;
         chan_r    <= 2'd0;
         count_r   <= 16'd0;
         owner_r   <= '0;
         lo_byte_r <= 8'd0;
         hi_byte_r <= 8'd0;
      end else begin
         if (advance_s) begin
            op_r    <= sel_op_s;
            chan_r  <= sel_chan_s;
            count_r <= sel_count_s;
            owner_r <= grant_oh_s;
         end
         if (t_rd_r && (state_r == ST_LO)) begin
            lo_byte_r <= t_dout;
         end
         if (t_rd_r && (state_r == ST_HI)) begin
            hi_byte_r <= t_dout;
         end
      end
   end

   assign done  = done_r;
   assign err   = err_r;
   assign rdata = rdata_r;
   assign t_a   = t_a_r;
   assign t_wr  = t_wr_r;
   assign t_rd  = t_rd_r;
   assign t_din = t_din_r;

endmodule

// File: tb/tb_i8253_sequencer.sv
// Scoreboard bench for i8253_sequencer: expected bus cycles and done pulses are
// queued when a request is driven and compared as the DUT produces them.
module tb_i8253_sequencer;

   localparam int NREQ = 3;

   typedef struct packed {
      logic       rd;
      logic [1:0] a;
      logic [7:0] d;
   } bus_ev_t;

   typedef struct packed {
      logic [NREQ-1:0] oh;
      logic            err;
      logic [15:0]     rdata;
   } done_ev_t;

   typedef struct {
      int         c;
      logic       rd;
      logic [1:0] a;
      logic [7:0] d;
   } g0_ev_t;

   logic clk = 1'b0;
   logic rst_n;
   logic [NREQ-1:0]    req_valid, req_op, req_bcd;
   logic [NREQ*2-1:0]  req_chan;
   logic [NREQ*3-1:0]  req_mode;
   logic [NREQ*16-1:0] req_count;
   logic [NREQ-1:0]    done;
   logic               err, t_wr, t_rd;
   logic [15:0]        rdata;
   logic [1:0]         t_a;
   logic [7:0]         t_din, t_dout;

   logic [NREQ-1:0]    g0_valid, g0_op, g0_bcd;
   logic [NREQ*2-1:0]  g0_chan;
   logic [NREQ*3-1:0]  g0_mode;
   logic [NREQ*16-1:0] g0_count;
   logic [NREQ-1:0]    g0_done;
   logic               g0_err, g0_t_wr, g0_t_rd;
   logic [15:0]        g0_rdata;
   logic [1:0]         g0_t_a;
   logic [7:0]         g0_t_din;
   logic [7:0]         g0_t_dout = 8'h00;

   bus_ev_t  exp_bus[$];
   done_ev_t exp_done[$];
   g0_ev_t   g0_obs[$];

   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   int          model_ptr = 0;
   logic [15:0] last_rdata = 16'h0000;
   logic [7:0]  rd_lo = 8'h00;
   logic [7:0]  rd_hi = 8'h00;
   logic        rd_ptr;
   logic        overlap = 1'b0;
   logic        g0_overlap = 1'b0;

   always #5 clk = ~clk;

   i8253_sequencer #(.NREQ(NREQ), .STROBE_GAP(1)) u_dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_op(req_op),
      .req_chan(req_chan), .req_mode(req_mode), .req_bcd(req_bcd),
      .req_count(req_count), .done(done), .err(err), .rdata(rdata),
      .t_a(t_a), .t_wr(t_wr), .t_rd(t_rd), .t_din(t_din), .t_dout(t_dout)
   );

   i8253_sequencer #(.NREQ(NREQ), .STROBE_GAP(0)) u_dut_g0 (
      .clk(clk), .rst_n(rst_n), .req_valid(g0_valid), .req_op(g0_op),
      .req_chan(g0_chan), .req_mode(g0_mode), .req_bcd(g0_bcd),
      .req_count(g0_count), .done(g0_done), .err(g0_err), .rdata(g0_rdata),
      .t_a(g0_t_a), .t_wr(g0_t_wr), .t_rd(g0_t_rd), .t_din(g0_t_din), .t_dout(g0_t_dout)
   );

   // Timer read model: LSB first, then MSB; the byte pointer flips on each read strobe.
   assign t_dout = rd_ptr ? rd_hi : rd_lo;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) rd_ptr <= 1'b0;
      else if (t_rd) rd_ptr <= ~rd_ptr;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Queue the bus cycles and done pulse a single granted request should produce.
   task automatic push_op(input int idx, input logic op, input logic [1:0] chan,
                          input logic [2:0] mode, input logic bcd, input logic [15:0] cnt);
      logic [NREQ-1:0] oh;
      oh = '0;
      oh[idx] = 1'b1;
      if (chan == 2'd3) begin
         exp_done.push_back(done_ev_t'({oh, 1'b1, last_rdata}));
      end else begin
         if (op) begin
            exp_bus.push_back(bus_ev_t'({1'b0, 2'd3, chan, 6'b000000}));
            exp_bus.push_back(bus_ev_t'({1'b1, chan, 8'h00}));
            exp_bus.push_back(bus_ev_t'({1'b1, chan, 8'h00}));
            last_rdata = {rd_hi, rd_lo};
         end else begin
            exp_bus.push_back(bus_ev_t'({1'b0, 2'd3, chan, 2'b11, mode, bcd}));
            exp_bus.push_back(bus_ev_t'({1'b0, chan, cnt[7:0]}));
            exp_bus.push_back(bus_ev_t'({1'b0, chan, cnt[15:8]}));
         end
         exp_done.push_back(done_ev_t'({oh, 1'b0, last_rdata}));
      end
      model_ptr = (idx + 1) % NREQ;
   endtask

   task automatic set_req(input int idx, input logic op, input logic [1:0] chan,
                          input logic [2:0] mode, input logic bcd, input logic [15:0] cnt);
      req_op[idx]           = op;
      req_chan[2*idx +: 2]  = chan;
      req_mode[3*idx +: 3]  = mode;
      req_bcd[idx]          = bcd;
      req_count[16*idx +: 16] = cnt;
   endtask

   // One isolated request from IDLE; checks the done latency, ends in the next IDLE cycle.
   task automatic run_op(input int idx, input logic op, input logic [1:0] chan,
                         input logic [2:0] mode, input logic bcd, input logic [15:0] cnt);
      int start;
      int n;
      push_op(idx, op, chan, mode, bcd, cnt);
      set_req(idx, op, chan, mode, bcd, cnt);
      req_valid[idx] = 1'b1;
      start = cyc;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done[idx] && n < 40);
      check_eq("latency", 32'(cyc - start), (chan == 2'd3) ? 32'd1 : 32'd7);
      req_valid[idx] = 1'b0;
      @(negedge clk);
   endtask

   // Main DUT monitor: pops the scoreboard on every strobe and every done pulse.
   initial begin
      bus_ev_t  obs_b;
      done_ev_t obs_d;
      forever begin
         @(negedge clk);
         if (t_wr && t_rd) overlap = 1'b1;
         if (t_wr || t_rd) begin
            obs_b = bus_ev_t'({t_rd, t_a, t_rd ? 8'h00 : t_din});
            if (exp_bus.size() == 0) check_eq("bus_unexpected", 32'(obs_b), 32'hDEAD_0000);
            else check_eq("bus_cycle", 32'(obs_b), 32'(exp_bus.pop_front()));
         end
         if (|done) begin
            obs_d = done_ev_t'({done, err, rdata});
            if (exp_done.size() == 0) check_eq("done_unexpected", 32'(obs_d), 32'hDEAD_0000);
            else check_eq("done_err_rdata", 32'(obs_d), 32'(exp_done.pop_front()));
         end
      end
   end

   // Zero-gap DUT monitor: records every strobe with its cycle number.
   initial begin
      g0_ev_t ev;
      forever begin
         @(negedge clk);
         if (g0_t_wr && g0_t_rd) g0_overlap = 1'b1;
         if (g0_t_wr || g0_t_rd) begin
            ev.c  = cyc;
            ev.rd = g0_t_rd;
            ev.a  = g0_t_a;
            ev.d  = g0_t_din;
            g0_obs.push_back(ev);
         end
      end
   end

   initial begin
      int p;
      int n_done;
      int guard;
      int start;
      logic [1:0] g0_a_exp [3];
      logic [7:0] g0_d_exp [3];

      rst_n = 1'b0;
      req_valid = '0; req_op = '0; req_bcd = '0; req_chan = '0; req_mode = '0; req_count = '0;
      g0_valid = '0; g0_op = '0; g0_bcd = '0; g0_chan = '0; g0_mode = '0; g0_count = '0;
      repeat (3) @(negedge clk);
      check_eq("rst_done",  32'(done),  32'd0);
      check_eq("rst_err",   32'(err),   32'd0);
      check_eq("rst_rdata", 32'(rdata), 32'd0);
      check_eq("rst_t_a",   32'(t_a),   32'd0);
      check_eq("rst_t_wr",  32'(t_wr),  32'd0);
      check_eq("rst_t_rd",  32'(t_rd),  32'd0);
      check_eq("rst_t_din", 32'(t_din), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Program and read sequences, including count 0 and mode 5 passthrough.
      run_op(0, 1'b0, 2'd0, 3'd3, 1'b0, 16'h1234);
      run_op(1, 1'b0, 2'd2, 3'd0, 1'b0, 16'h0000);
      rd_lo = 8'hCD; rd_hi = 8'hAB;
      run_op(2, 1'b1, 2'd2, 3'd0, 1'b0, 16'h0000);
      check_eq("rdata_hold", 32'(rdata), 32'h0000_ABCD);
      run_op(0, 1'b0, 2'd1, 3'd5, 1'b1, 16'hFFFF);
      check_eq("rdata_kept", 32'(rdata), 32'h0000_ABCD);
      rd_lo = 8'h5A; rd_hi = 8'hA5;
      run_op(0, 1'b1, 2'd0, 3'd0, 1'b0, 16'h0000);

      // Illegal channel: immediate done with err, no bus cycles.
      run_op(1, 1'b0, 2'd3, 3'd2, 1'b0, 16'h4321);

      // All three requesters held: grants rotate from the model pointer.
      p = model_ptr;
      for (int i = 0; i < NREQ; i++)
         set_req(i, 1'b0, 2'(i), 3'(i + 1), 1'b0, 16'(16'h1111 * (i + 1)));
      for (int k = 0; k < 6; k++)
         push_op((p + k) % NREQ, 1'b0, 2'((p + k) % NREQ), 3'((p + k) % NREQ + 1), 1'b0,
                 16'(16'h1111 * ((p + k) % NREQ + 1)));
      req_valid = '1;
      n_done = 0;
      guard = 0;
      while (n_done < 6 && guard < 200) begin
         @(negedge clk);
         guard++;
         if (|done) begin
            n_done++;
            if (n_done == 6) req_valid = '0;
         end
      end
      check_eq("held_done_count", 32'(n_done), 32'd6);
      @(negedge clk);

      // Reset in the gap after the LSB write: strobes/outputs clear, no done.
      exp_bus.push_back(bus_ev_t'({1'b0, 2'd3, 8'h70}));
      exp_bus.push_back(bus_ev_t'({1'b0, 2'd1, 8'h78}));
      set_req(1, 1'b0, 2'd1, 3'd0, 1'b0, 16'h5678);
      req_valid[1] = 1'b1;
      start = cyc;
      repeat (4) @(negedge clk);
      check_eq("abort_in_gap_t_din", 32'(t_din), 32'h78);
      rst_n = 1'b0;
      req_valid = '0;
      #1;
      check_eq("abort_t_wr",  32'(t_wr),  32'd0);
      check_eq("abort_t_rd",  32'(t_rd),  32'd0);
      check_eq("abort_done",  32'(done),  32'd0);
      check_eq("abort_t_a",   32'(t_a),   32'd0);
      check_eq("abort_t_din", 32'(t_din), 32'd0);
      last_rdata = 16'h0000;
      model_ptr = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_op(1, 1'b0, 2'd1, 3'd4, 1'b0, 16'h9ABC);

      // Zero-gap instance: strobes on consecutive cycles, done at cycle 4.
      g0_obs.delete();
      g0_op[0] = 1'b0; g0_chan[1:0] = 2'd1; g0_mode[2:0] = 3'd2; g0_bcd[0] = 1'b1;
      g0_count[15:0] = 16'hBEEF;
      g0_valid[0] = 1'b1;
      start = cyc;
      guard = 0;
      do begin
         @(negedge clk);
         guard++;
      end while (!g0_done[0] && guard < 20);
      check_eq("g0_latency", 32'(cyc - start), 32'd4);
      check_eq("g0_done_err", 32'({g0_done, g0_err}), 32'({3'b001, 1'b0}));
      check_eq("g0_rdata", 32'(g0_rdata), 32'd0);
      g0_valid = '0;
      @(negedge clk);
      g0_a_exp[0] = 2'd3; g0_a_exp[1] = 2'd1; g0_a_exp[2] = 2'd1;
      g0_d_exp[0] = 8'h75; g0_d_exp[1] = 8'hEF; g0_d_exp[2] = 8'hBE;
      check_eq("g0_strobe_count", 32'(g0_obs.size()), 32'd3);
      for (int k = 0; k < 3 && k < g0_obs.size(); k++) begin
         check_eq("g0_cycle", 32'(g0_obs[k].c - start), 32'(k + 1));
         check_eq("g0_bus", 32'({g0_obs[k].rd, g0_obs[k].a, g0_obs[k].d}),
                  32'({1'b0, g0_a_exp[k], g0_d_exp[k]}));
      end

      check_eq("wr_rd_overlap", 32'(overlap), 32'd0);
      check_eq("g0_wr_rd_overlap", 32'(g0_overlap), 32'd0);
      check_eq("bus_left", 32'(exp_bus.size()), 32'd0);
      check_eq("done_left", 32'(exp_done.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
